// File: rtl/rate_meter_pkg.sv
// rate_meter_pkg: shared FSM states, default widths and window-length decode for the pulse rate meter
package rate_meter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, HOLD = 2'd2} state_t;
  localparam int DEF_CNT_W = 9;
  localparam int DEF_WIN_W = 8;
  function automatic int unsigned win_ticks(input int unsigned len, input int unsigned win_w);
    return (len == 0) ? (32'd1 << win_w) : len;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at all-ones and raises a sticky flag on any increment attempted there
module sat_counter #(
  parameter int W = 9
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_sat
);
  logic [W-1:0] r_cnt;
  logic         r_sat;
  logic         w_max;
  assign w_max = &r_cnt;
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (i_inc) begin
      r_cnt <= w_max ? r_cnt : r_cnt + 1'b1;
      r_sat <= r_sat | w_max;
    end
  end
  assign o_cnt = r_cnt;
  assign o_sat = r_sat;
endmodule

// File: rtl/pulse_rate_meter.sv
// pulse_rate_meter: counts pz pulses over a window of enable ticks and offers the count on a valid/ready result port
module pulse_rate_meter
  import rate_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_tick_en,
  input  logic             i_pulse_in,
  input  logic [WIN_W-1:0] i_win_len,
  input  logic             i_start,
  input  logic             i_cont,
  output logic             o_busy,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [CNT_W-1:0] o_res_count,
  output logic             o_res_ovf
);
  state_t           r_state;
  logic [WIN_W-1:0] r_len;
  logic [WIN_W:0]   r_rem;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [CNT_W-1:0] w_acc;
  logic             w_acc_ovf;
  logic             w_start, w_hs, w_restart, w_tick, w_last, w_clr, w_inc;
  assign w_start   = (r_state == IDLE) && i_start;
  assign w_hs      = (r_state == HOLD) && i_res_ready;
  assign w_restart = w_hs && i_cont;
  assign w_tick    = (r_state == COUNT) && i_tick_en;
  assign w_last    = w_tick && (r_rem == {{WIN_W{1'b0}}, 1'b1});
  assign w_inc     = w_tick && i_pulse_in;
  assign w_clr     = w_start || w_restart;
  sat_counter #(.W(CNT_W)) u_acc (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_cnt   (w_acc),
    .o_sat   (w_acc_ovf)
  );
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_rem   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_start) begin
        r_len <= i_win_len;
        r_rem <= (WIN_W+1)'(win_ticks(32'(i_win_len), WIN_W));
      end else if (w_restart) begin
        r_rem <= (WIN_W+1)'(win_ticks(32'(r_len), WIN_W));
      end else if (w_tick) begin
        r_rem <= r_rem - 1'b1;
      end
      if (w_hs) begin
        r_count <= w_acc;
        r_ovf   <= w_acc_ovf;
      end
      r_state <= w_clr ? COUNT : w_last ? HOLD : w_hs ? IDLE : r_state;
    end
  end
  // In HOLD the frozen accumulator is the result; afterwards the captured copy persists until the next result
  assign o_busy      = r_state != IDLE;
  assign o_res_valid = r_state == HOLD;
  assign o_res_count = (r_state == HOLD) ? w_acc : r_count;
  assign o_res_ovf   = (r_state == HOLD) ? w_acc_ovf : r_ovf;
endmodule

// File: tb/tb_pulse_rate_meter.sv
// tb_pulse_rate_meter: directed and randomized windows checked against a pulse-counting reference model
module tb_pulse_rate_meter;
  logic       clk = 1'b0;
  logic       rst, tick_en, pulse_in, start, cont, res_ready;
  logic [7:0] win_len;
  logic       busy_a, valid_a, ovf_a, busy_b, valid_b, ovf_b;
  logic [8:0] cnt_a;
  logic [3:0] cnt_b;
  int         checks = 0;
  int         failures = 0;
  int         exp_raw = 0;
  always #5 clk = ~clk;
  pulse_rate_meter #(.CNT_W(9), .WIN_W(8)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_tick_en(tick_en), .i_pulse_in(pulse_in),
    .i_win_len(win_len), .i_start(start), .i_cont(cont), .o_busy(busy_a),
    .o_res_valid(valid_a), .i_res_ready(res_ready), .o_res_count(cnt_a), .o_res_ovf(ovf_a)
  );
  pulse_rate_meter #(.CNT_W(4), .WIN_W(8)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_tick_en(tick_en), .i_pulse_in(pulse_in),
    .i_win_len(win_len), .i_start(start), .i_cont(cont), .o_busy(busy_b),
    .o_res_valid(valid_b), .i_res_ready(res_ready), .o_res_count(cnt_b), .o_res_ovf(ovf_b)
  );
  function automatic int sat(input int c, input int w);
    return (c > (1 << w) - 1) ? (1 << w) - 1 : c;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_result(input string tag);
    chk({tag, "_cnt_a"}, 32'(cnt_a), sat(exp_raw, 9));
    chk({tag, "_ovf_a"}, 32'(ovf_a), 32'(exp_raw > 511));
    chk({tag, "_cnt_b"}, 32'(cnt_b), sat(exp_raw, 4));
    chk({tag, "_ovf_b"}, 32'(ovf_b), 32'(exp_raw > 15));
  endtask
  task automatic do_start(input int w);
    start = 1'b1;
    win_len = 8'(w);
    @(negedge clk);
    start = 1'b0;
    chk("start_busy_a", 32'(busy_a), 1);
    chk("start_busy_b", 32'(busy_b), 1);
    chk("start_valid", 32'(valid_a), 0);
  endtask
  // tmode: 0 tick every cycle, 1 alternate, 2 random; pmode: 0 pulse always, else random
  task automatic count_window(input int n, input int tmode, input int pmode, input string tag);
    int  ticks = 0;
    int  cyc = 0;
    logic t, p;
    exp_raw = 0;
    while (ticks < n) begin
      chk({tag, "_valid_low"}, 32'(valid_a | valid_b), 0);
      t = (tmode == 0) ? 1'b1 : (tmode == 1) ? logic'(cyc % 2 == 0) :
          logic'((cyc > 4 * n) || ($urandom_range(0, 1) == 1));
      p = (pmode == 0) ? 1'b1 : logic'($urandom_range(0, 1));
      tick_en = t;
      pulse_in = p;
      if (t) begin
        ticks++;
        if (p) exp_raw++;
      end
      cyc++;
      @(negedge clk);
    end
    tick_en = 1'b0;
    pulse_in = logic'($urandom_range(0, 1));
    chk({tag, "_valid_a"}, 32'(valid_a), 1);
    chk({tag, "_valid_b"}, 32'(valid_b), 1);
    check_result(tag);
  endtask
  task automatic accept(input logic c, input string tag);
    res_ready = 1'b1;
    cont = c;
    @(negedge clk);
    res_ready = 1'b0;
    cont = 1'b0;
    chk({tag, "_acc_valid"}, 32'(valid_a | valid_b), 0);
    chk({tag, "_acc_busy"}, 32'(busy_a), 32'(c));
    check_result({tag, "_kept"});
  endtask
  initial begin
    rst = 1'b1; tick_en = 1'b0; pulse_in = 1'b0; start = 1'b0;
    cont = 1'b0; res_ready = 1'b0; win_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_a | busy_b), 0);
    chk("rst_valid", 32'(valid_a | valid_b), 0);
    chk("rst_cnt", 32'(cnt_a) + 32'(cnt_b), 0);
    chk("rst_ovf", 32'(ovf_a | ovf_b), 0);
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("idle_ready_valid", 32'(valid_a), 0);
    chk("idle_ready_busy", 32'(busy_a), 0);
    do_start(0);
    count_window(256, 0, 0, "full");
    accept(1'b0, "full");
    do_start(10);
    count_window(10, 1, 0, "alt");
    accept(1'b0, "alt");
    do_start(20);
    count_window(20, 0, 0, "sat");
    accept(1'b0, "sat");
    do_start(1);
    count_window(1, 0, 0, "one");
    for (int i = 0; i < 5; i++) begin
      tick_en = logic'($urandom_range(0, 1));
      pulse_in = 1'b1;
      start = logic'(i % 2);
      @(negedge clk);
      chk("hold_valid", 32'(valid_a), 1);
      check_result("hold");
    end
    start = 1'b0;
    accept(1'b0, "hold");
    @(negedge clk);
    chk("idle_busy", 32'(busy_a), 0);
    do_start(5);
    count_window(5, 2, 2, "cont1");
    win_len = 8'd3;
    accept(1'b1, "cont1");
    count_window(5, 2, 2, "cont2");
    accept(1'b0, "cont2");
    do_start(50);
    for (int i = 0; i < 5; i++) begin
      tick_en = 1'b1;
      pulse_in = 1'b1;
      @(negedge clk);
    end
    tick_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy_a | busy_b), 0);
    chk("mid_rst_valid", 32'(valid_a | valid_b), 0);
    chk("mid_rst_cnt", 32'(cnt_a), 0);
    do_start(4);
    count_window(4, 0, 0, "fresh");
    accept(1'b0, "fresh");
    for (int k = 0; k < 8; k++) begin
      int w;
      w = int'($urandom_range(1, 40));
      do_start(w);
      count_window(w, 2, 2, "rand");
      accept(1'b0, "rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pulse_rate_meter.md
Name: pulse_rate_meter

Overview:
- Downstream consumer of the rate-multiplier stage's pulse output (pz).
- Counts output pulses over a programmable window of enable ticks (the same pp_0 tick that advances the rate multiplier), then presents the count on a valid/ready result interface.
- Lets firmware or test logic confirm the programmed fractional rate without free-running observation.

Parameters:
- CNT_W, 9, width of pulse count result; must hold 2^WIN_W.
- WIN_W, 8, width of window-length field; window ranges 1..2^WIN_W ticks.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- tick_en  in  1  enable tick (pp_0 of the rate multiplier); one window tick per cycle with tick_en=1.
- pulse_in  in  1  rate multiplier output pz; counted only when tick_en=1.
- win_len  in  WIN_W  window length in ticks; 0 encodes 2^WIN_W.
- start  in  1  request a measurement; sampled only in IDLE.
- cont  in  1  continuous mode; sampled at result handshake.
- busy  out  1  high in COUNT and HOLD.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_count  out  CNT_W  pulses counted in the window.
- res_ovf  out  1  count saturated during the window.

Behaviour:
- Reset (synchronous, active-high) values: state=IDLE, busy=0, res_valid=0, res_count=0, res_ovf=0, internal tick counter=0, latched length=0.
- Reset mid-operation aborts the window; any pending result is discarded.
- FSM states:
  - IDLE.
  - COUNT.
  - HOLD.
- IDLE:
  - start=1 latches win_len into len_q and loads remaining=len_q (0 maps to 2^WIN_W, so remaining needs WIN_W+1 bits).
  - Clears acc and ovf; next state COUNT.
  - busy rises on the following cycle.
- COUNT:
  - Each cycle with tick_en=1 decrements remaining.
  - If pulse_in=1 in the same cycle, acc increments.
  - At max 2^CNT_W-1, acc holds and ovf is set sticky.
  - pulse_in with tick_en=0 is ignored.
  - The tick that brings remaining to 0 is counted. Next state is HOLD, with res_count=final acc (including that tick's pulse) and res_valid=1 on the next cycle.
  - Latency: last window tick at cycle t gives res_valid=1 at t+1.
- HOLD:
  - res_valid, res_count and res_ovf stay stable until res_valid&res_ready.
  - All tick_en and pulse_in activity is ignored.
  - On handshake with cont=0: next state IDLE, res_valid=0.
  - On handshake with cont=1: restart COUNT immediately with len_q reused (win_len is not re-sampled), acc=0, ovf=0.
  - res_count keeps the last value until the next result loads.
- res_ready in IDLE or COUNT has no effect.
- start outside IDLE is ignored and not queued.
- tick_en held low: COUNT waits indefinitely; there is no timeout.
- Window of length 1: a single tick ends the window.

Decomposition:
- Shared package (rate_meter_pkg):
  - state enum {IDLE, COUNT, HOLD}.
  - Default CNT_W/WIN_W constants.
  - Function mapping win_len=0 to 2^WIN_W.
- Sub-module sat_counter (width param, clear, inc, saturate flag out) for acc/ovf. Tick countdown stays inline.

Test Plan:
- Reset, then win_len=0, start=1, tick_en=1 every cycle, pulse_in=1 every cycle -> exactly 256 ticks counted; res_valid at cycle 257 after entering COUNT; res_count=256, res_ovf=0.
- win_len=10, tick_en alternating 1/0, pulse_in=1 constantly -> window spans 20 cycles; res_count=10 (pulses on tick_en=0 ignored).
- CNT_W=4, win_len=20, pulse_in=1 on every tick -> res_count=15, res_ovf=1.
- Result pending, res_ready=0 for 5 cycles while pulses and start toggle -> res_valid/res_count unchanged; accepted on res_ready=1; returns to IDLE with cont=0.
- cont=1 at handshake, win_len changed to 3 -> next window reuses original len_q; back-to-back results with no IDLE cycle.
- reset asserted mid-COUNT (after 5 ticks) -> next cycle IDLE, busy=0, res_valid=0; a fresh start gives a count starting from 0.
